led_fade_scheduler: RTL

Sequences PWM duty values for NUM_CH LED channels, ramping each channel's duty toward a commanded target at a programmable step per slow tick. Sits between the UART command parser (upstream, valid/ready) and the PWM generators (downstream, one duty byte per channel). Its time base is the 100 Hz slow_clk from the clock divider, edge-detected in the clk domain. Channel updates are scheduled one channel per clk cycle after each tick.

---
 rtl/led_fade_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/led_fade_scheduler.sv
// led_fade_scheduler
//
// Ramps the PWM duty of NUM_CH LED channels toward commanded targets. Each
// rising edge of the 100 Hz slow_clk starts one update pass. A pass walks the
// channels in order, one per clk cycle, and moves each channel's duty toward
// its target by that channel's step. The duty never passes the target and
// never wraps.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   slow_clk    100 Hz tick source, already in the clk domain
//   cmd_valid   command present
//   cmd_ready   high in IDLE; a command is taken when valid && ready at a clk edge
//   cmd_chan    channel index; indices >= NUM_CH are accepted and dropped
//   cmd_target  target duty
//   cmd_step    ramp step per tick (0 freezes the channel)
//   cmd_imm     also load the target straight into the current duty
//   duty        current duty, channel i in bits [8i+7:8i]
//   busy        per channel, current duty != target
//   done        one-cycle pulse after a ramp step lands exactly on the target
module led_fade_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slow_clk,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_chan,
    input  logic [7:0]            cmd_target,
    input  logic [3:0]            cmd_step,
    input  logic                  cmd_imm,
    output logic [NUM_CH*8-1:0]   duty,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             pending_reg, pending_next;
    logic             slow_q_reg, slow_d_reg;
    logic             tick;
    logic             cmd_accept;
    logic             chan_ok;
    logic             step_en;

    // slow_clk is sampled once, then delayed once more. tick is high in the
    // cycle after the edge that first sees slow_clk high. The FSM therefore
    // enters UPDATE one edge later, and channel i moves at E0+2+i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_q_reg <= 1'b0;
            slow_d_reg <= 1'b0;
        end else begin
            slow_q_reg <= slow_clk;
            slow_d_reg <= slow_q_reg;
        end
    end

    assign tick = slow_q_reg & ~slow_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        cmd_ready    = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (tick || pending_reg) begin
                    state_next   = UPDATE;
                    idx_next     = '0;
                    pending_next = 1'b0;
                end
            end
            UPDATE: begin
                // A tick that lands mid-pass is remembered. It runs one more
                // pass straight after this one. Further ticks add nothing.
                if (tick) begin
                    pending_next = 1'b1;
                end
                if (idx_reg == IDX_W'(NUM_CH - 1)) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_accept = cmd_valid & cmd_ready;
    assign chan_ok    = 32'(cmd_chan) < NUM_CH;
    assign step_en    = (state_reg == UPDATE);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [7:0] cur_reg, tgt_reg;
            logic [3:0] stp_reg;
            logic       done_reg;
            logic [8:0] diff;
            logic       neg;
            logic [7:0] mag;
            logic       reach;
            logic       moving;
            logic [7:0] cur_step;
            logic       sel;
            logic       wr;

            // The signed 9-bit difference gives the direction and the distance.
            // If the distance fits within one step, the duty snaps to the
            // target, so it never overshoots or wraps.
            always_comb begin
                diff     = {1'b0, tgt_reg} - {1'b0, cur_reg};
                neg      = diff[8];
                mag      = neg ? 8'(9'd0 - diff) : diff[7:0];
                reach    = (mag <= {4'd0, stp_reg});
                moving   = (stp_reg != 4'd0) && (mag != 8'd0);
                cur_step = cur_reg;
                if (moving) begin
                    if (reach) begin
                        cur_step = tgt_reg;
                    end else if (neg) begin
                        cur_step = cur_reg - {4'd0, stp_reg};
                    end else begin
                        cur_step = cur_reg + {4'd0, stp_reg};
                    end
                end
            end

            assign sel = step_en && (idx_reg == IDX_W'(gi));
            assign wr  = cmd_accept && chan_ok && (cmd_chan == CH_W'(gi));

            // Command writes happen only in IDLE and ramp steps only in UPDATE,
            // so the two branches never compete for the same cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cur_reg  <= 8'd0;
                    tgt_reg  <= 8'd0;
                    stp_reg  <= 4'd0;
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= 1'b0;
                    if (wr) begin
                        tgt_reg <= cmd_target;
                        stp_reg <= cmd_step;
                        if (cmd_imm) begin
                            cur_reg <= cmd_target;
                        end
                    end else if (sel) begin
                        cur_reg  <= cur_step;
                        done_reg <= moving && reach;
                    end
                end
            end

            assign duty[8*gi +: 8] = cur_reg;
            assign busy[gi]        = (cur_reg != tgt_reg);
            assign done[gi]        = done_reg;
        end
    endgenerate

endmodule
